// File: rtl/booth_prod_bcd.sv
// booth_prod_bcd: signed product -> sign + packed BCD magnitude using an iterative double-dabble engine.
// Optional seven-segment output (out_seg) is enabled by defining BOOTH_PROD_SEVSEG_EN.
module booth_prod_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_sign,
    output logic [4*DIGITS-1:0]      out_bcd,
`ifdef BOOTH_PROD_SEVSEG_EN
    output logic [7*(DIGITS+1)-1:0]  out_seg,
`endif
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               load_c;
    logic               last_c;
    logic               sign_r;
    logic [WIDTH-1:0]   mag_r;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     mag_c;
    logic [BCD_W-1:0]   adj_c;
    logic [BCD_W-1:0]   scratch_nxt_c;
    logic               sign_fin_c;

    assign in_ready = (state == IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CONV;
                    load_c    = 1'b1;
                end
            end
            CONV: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                    last_c    = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Magnitude is one bit wider so that -2^(WIDTH-1) negates without overflow
    always_comb begin
        mag_c = in_data[WIDTH-1] ? (~{1'b1, in_data} + (WIDTH+1)'(1)) : {1'b0, in_data};
    end

    // One double-dabble step: add 3 to digits >= 5, then shift in the next magnitude bit
    always_comb begin
        adj_c = scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_nxt_c = BCD_W'({adj_c, mag_r[WIDTH-1]});
        sign_fin_c    = sign_r & (|scratch_nxt_c);
    end

    // Conversion datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r    <= 1'b0;
            mag_r     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            out_sign  <= 1'b0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load_c) begin
                sign_r  <= in_data[WIDTH-1];
                mag_r   <= WIDTH'(mag_c);
                scratch <= '0;
                cnt     <= CNT_W'(WIDTH);
            end else if (state == CONV) begin
                scratch <= scratch_nxt_c;
                mag_r   <= {mag_r[WIDTH-2:0], 1'b0};
                cnt     <= cnt - CNT_W'(1);
            end
            if (last_c) begin
                out_bcd   <= scratch_nxt_c;
                out_sign  <= sign_fin_c;
                out_valid <= 1'b1;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef BOOTH_PROD_SEVSEG_EN
    localparam int unsigned SEG_W = 7 * (DIGITS + 1);

    logic [SEG_W-1:0] seg_c;
    logic             lead_c;

    // gfedcba pattern for one BCD digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Leading zeros above the units digit stay blank; top group carries the minus sign
    always_comb begin
        seg_c  = '0;
        lead_c = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if ((scratch_nxt_c[4*i +: 4] != 4'd0) || (i == 0)) begin
                lead_c = 1'b0;
            end
            if (!lead_c) begin
                seg_c[7*i +: 7] = seg7(scratch_nxt_c[4*i +: 4]);
            end
        end
        seg_c[7*DIGITS +: 7] = sign_fin_c ? 7'h40 : 7'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_seg <= '0;
        end else if (last_c) begin
            out_seg <= seg_c;
        end
    end
`endif

endmodule

// File: doc/booth_prod_bcd.md
Name: booth_prod_bcd

Overview:
- Downstream stage of the 4x4 Booth multiplier.
- Takes the signed two's-complement product, converts it to sign + packed BCD digits with an iterative shift-add-3 (double-dabble) engine, and presents it to the display/readout logic.
- One conversion at a time; valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, product width in bits (two's complement).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^(WIDTH-1); 3 is sufficient for WIDTH=8 (max magnitude 128).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH  signed product from the multiplier
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept in_data
- out_sign  out  1  1 = negative result
- out_bcd  out  4*DIGITS  packed BCD magnitude; digit 0 (units) in bits [3:0]
- out_valid  out  1  out_sign/out_bcd are valid
- out_ready  in  1  consumer accepts the result

Behaviour:
- Reset (async, rst=1): state=IDLE; out_sign=0, out_bcd=0, out_valid=0; internal shift register and counter cleared. in_ready=1 once rst deasserts.
- States: IDLE, CONV, DONE.
- in_ready = (state==IDLE), combinational from state only. out_valid = (state==DONE), registered.
- IDLE, in_valid=1 at edge N:
  - capture sign = in_data[WIDTH-1]
  - magnitude = sign ? (~in_data + 1) : in_data, computed WIDTH+1 bits wide so -2^(WIDTH-1) yields 2^(WIDTH-1) with no overflow
  - BCD scratch = 0, counter = WIDTH; go to CONV.
- CONV, one iteration per cycle:
  - every scratch digit >= 5 gets +3
  - then {scratch, magnitude} shift left by 1
  - counter decrements.
- When the counter reaches 0, register the final scratch into out_bcd and the sign into out_sign, then go to DONE.
  - out_valid rises at edge N+WIDTH (8 cycles for the default).
  - Zero magnitude forces out_sign=0; no negative zero.
- DONE: out_sign/out_bcd/out_valid are held stable while out_ready=0. When out_ready=1 at an edge, go to IDLE and drop out_valid. out_bcd/out_sign keep their last value.
- Throughput: one result per WIDTH+2 cycles minimum. No input accepted in CONV or DONE; in_valid is ignored there and the upstream must hold its data.
- out_ready asserted while not in DONE: ignored.
- in_valid and out_ready both high in DONE: only the DONE->IDLE transition occurs; the input is accepted no earlier than the following cycle.
- Reset mid-CONV or mid-DONE: conversion aborted; all outputs return to reset values immediately (asynchronously).
- All arithmetic is unsigned on magnitude and digits; digit +3 is 4-bit with no carry out (never overflows since the digit is <= 9 before the shift).

Optional Feature:
- Macro: BOOTH_PROD_SEVSEG_EN.
- Defined:
  - extra output port out_seg, 7*(DIGITS+1) bits, active-high segments gfedcba per digit.
  - Digit i in bits [7i+6:7i]; the top group is the sign digit (segment g only when out_sign=1, blank otherwise).
  - Registered in the same edge as out_bcd; reset value 0.
  - Leading-zero digits above the units digit are blanked.
- Undefined: port out_seg absent, no segment logic; all other behaviour identical.

Test Plan:
- Reset then in_data=0x00 -> 8 cycles later out_valid=1, out_sign=0, out_bcd=0x000; with SEVSEG_EN, out_seg units = 0x3F, all other groups 0.
- in_data=0x40 (+64) -> out_sign=0, out_bcd=0x064. Then in_data=0xC8 (-56) -> out_sign=1, out_bcd=0x056.
- in_data=0x80 (-128) -> out_sign=1, out_bcd=0x128. in_data=0x7F -> out_sign=0, out_bcd=0x127.
- Hold out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, out_bcd/out_sign stay stable, in_ready=0 while in_valid=1. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Assert rst 3 cycles into CONV (in_data=0xF7) -> out_valid=0 and out_bcd=0 immediately. After release, in_data=0xF7 -> out_sign=1, out_bcd=0x009.
- Back-to-back in_valid held high with out_ready=1 -> results for 0x01, 0xFF, 0x24 arrive in order: +001, -001, +036. Spacing is WIDTH+2 cycles.
